bit_serial_adder4: RTL and testbench

- Bit-serial 4-bit adder that sits directly downstream of the 4-bit 2:1 operand mux. The mux's Y output drives operand a.
- On start it captures both operands and adds them LSB-first, one bit per clock, through a single full-adder cell.
- It then presents a registered sum and carry with a one-cycle done pulse.
- It is the area-minimal sequential counterpart to the ripple-carry adders in the lab set.

---
 rtl/bit_serial_adder4_pkg.sv | 18 +
 rtl/bit_serial_adder4_full_adder.sv | 29 ++
 rtl/bit_serial_adder4.sv | 167 ++++++++++++++++
 tb/tb_bit_serial_adder4.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder4_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_adder4_pkg
// Shared constants for the bit-serial adder: FSM state encodings and the
// default operand width.
// -----------------------------------------------------------------------------
package bit_serial_adder4_pkg;

  // Default operand/sum width (also the number of ADD cycles per operation).
  localparam int WIDTH_DEFAULT = 4;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : bit_serial_adder4_pkg

// File: rtl/bit_serial_adder4_full_adder.sv
// -----------------------------------------------------------------------------
// bit_serial_adder4_full_adder
// Purely combinational 1-bit full adder; the single arithmetic cell that the
// serial adder reuses on every ADD cycle.
//
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module bit_serial_adder4_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_s;

  // Sum and carry of the three input bits.
  always_comb begin
    half_s = a ^ b;
    s      = half_s ^ cin;
    cout   = (a & b) | (cin & half_s);
  end

endmodule : bit_serial_adder4_full_adder

// File: rtl/bit_serial_adder4.sv
// -----------------------------------------------------------------------------
// bit_serial_adder4
// Bit-serial unsigned adder. On an accepted start the operands and carry-in are
// captured, then added LSB-first through one full-adder cell, one bit per
// clock. After WIDTH ADD cycles the result is published on sum/cout together
// with a one-cycle done pulse. {cout,sum} = a + b + cin.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   start  : begin an addition (only honoured in IDLE)
//   a, b   : operands (WIDTH bits)
//   cin    : carry into the LSB
//   sum    : registered result, held until the next result is published
//   cout   : registered carry out of the MSB, held with sum
//   busy   : high while adding
//   done   : one-cycle pulse when sum/cout become valid
// -----------------------------------------------------------------------------
module bit_serial_adder4
  import bit_serial_adder4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_r;
  state_e           state_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_sr_r;
  logic [WIDTH-1:0] sum_sr_s;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  logic             fa_sum_s;
  logic             fa_cout_s;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  bit_serial_adder4_full_adder u_full_adder (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Next sum-shift-register value and final-bit detection.
  always_comb begin
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    sum_sr_s = (sum_sr_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
    last_s   = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ADD;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Serial datapath: operand capture, per-bit shift/add, result publication.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      sum_sr_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            sum_sr_r <= {WIDTH{1'b0}};
            carry_r  <= cin;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        ST_ADD: begin
          a_sr_r   <= a_sr_r >> 1;
          b_sr_r   <= b_sr_r >> 1;
          sum_sr_r <= sum_sr_s;
          carry_r  <= fa_cout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          // Publish only on the final bit so partial sums never reach sum.
          if (last_s) begin
            sum_r  <= sum_sr_s;
            cout_r <= fa_cout_s;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_ADD);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule : bit_serial_adder4

// File: tb/tb_bit_serial_adder4.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder4
// Directed self-checking bench for bit_serial_adder4 (WIDTH = 4). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       busy;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit_serial_adder4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for done after a start has been applied at the current
  // falling edge. lat = falling edges until done (-1 on timeout), bcnt = busy
  // samples seen, leak = sum/cout moved before done. Drops start after the
  // capture edge unless hold is set.
  task automatic wait_done(input bit hold, output int lat, output int bcnt,
                           output bit leak);
    logic [4:0] prev;
    prev = {cout, sum};
    lat  = -1;
    bcnt = 0;
    leak = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
      if ({cout, sum} !== prev) leak = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({sum, cout, busy, done} !== 7'b0000_000)
      $display("FAIL reset_state: sum=%h cout=%b busy=%b done=%b, required all 0",
               sum, cout, busy, done);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    int lat, bcnt; bit leak;
    a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
    wait_done(1'b0, lat, bcnt, leak);
    total_cnt++;
    if (lat !== 5) $display("FAIL basic_latency: got %0d, required 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (bcnt !== 4) $display("FAIL basic_busy_cycles: got %0d, required 4", bcnt);
    else pass_cnt++;
    total_cnt++;
    if (leak !== 1'b0) $display("FAIL basic_visibility: sum changed before done");
    else pass_cnt++;
    total_cnt++;
    if ({cout, sum} !== 5'd11 || busy !== 1'b0)
      $display("FAIL basic_result: cout=%b sum=%0d busy=%b, required 0 11 0", cout, sum, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || sum !== 4'd11)
      $display("FAIL basic_done_pulse: done=%b sum=%0d, required 0 11", done, sum);
    else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    int lat, bcnt; bit leak;
    a = 4'hF; b = 4'h1; cin = 1'b0; start = 1'b1;
    wait_done(1'b0, lat, bcnt, leak);
    total_cnt++;
    if (lat !== 5 || cout !== 1'b1 || sum !== 4'h0)
      $display("FAIL carry_f_plus_1: lat=%0d cout=%b sum=%h, required 5 1 0", lat, cout, sum);
    else pass_cnt++;
    @(negedge clk);
    a = 4'hF; b = 4'hF; cin = 1'b1; start = 1'b1;
    wait_done(1'b0, lat, bcnt, leak);
    total_cnt++;
    if (lat !== 5 || cout !== 1'b1 || sum !== 4'hF)
      $display("FAIL carry_f_plus_f_cin: lat=%0d cout=%b sum=%h, required 5 1 f", lat, cout, sum);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat; int extra;
    a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a = 4'd9; b = 4'd9; cin = 1'b1;
      end
      if (k == 2) begin
        start = 1'b1; a = 4'd15; b = 4'd12;
      end
      if (k == 3) begin
        start = 1'b0; a = 4'd1; b = 4'd2; cin = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    total_cnt++;
    if (lat !== 5 || cout !== 1'b0 || sum !== 4'd7)
      $display("FAIL isolation_result: lat=%0d cout=%b sum=%0d, required 5 0 7", lat, cout, sum);
    else pass_cnt++;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ignored_start_queued: %0d busy/done samples, required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt; bit leak;
    a = 4'd7; b = 4'd8; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({sum, cout, busy, done} !== 7'b0000_000)
      $display("FAIL reset_mid_op: sum=%0d cout=%b busy=%b done=%b, required all 0",
               sum, cout, busy, done);
    else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'd0)
      $display("FAIL reset_abandons_op: busy=%b done=%b sum=%0d, required 0 0 0", busy, done, sum);
    else pass_cnt++;
    // start and reset on the same edge: reset must win.
    a = 4'd5; b = 4'd5; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_beats_start: busy=%b, required 0", busy);
    else pass_cnt++;
    a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
    wait_done(1'b0, lat, bcnt, leak);
    total_cnt++;
    if (lat !== 5 || cout !== 1'b0 || sum !== 4'd4)
      $display("FAIL after_reset_add: lat=%0d cout=%b sum=%0d, required 5 0 4", lat, cout, sum);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bad_res, bad_tim;
    logic [4:0] exp_v;
    logic [4:0] prev_v;
    bad_res = 0;
    bad_tim = 0;
    prev_v = {cout, sum};
    for (int i = 0; i < 512; i++) begin
      a = i[3:0]; b = i[7:4]; cin = i[8];
      exp_v = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0000, i[8]};
      start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 5) begin
          if (done !== 1'b1) bad_tim++;
          if ({cout, sum} !== exp_v) begin
            bad_res++;
            if (bad_res <= 4)
              $display("FAIL b2b_result: a=%0d b=%0d cin=%0d got %0d, required %0d",
                       i[3:0], i[7:4], i[8], {cout, sum}, exp_v);
          end
        end else begin
          if (done !== 1'b0) bad_tim++;
          if (k < 5 && {cout, sum} !== prev_v) bad_tim++;
          if (k == 6 && {cout, sum} !== exp_v) bad_tim++;
        end
      end
      prev_v = exp_v;
    end
    start = 1'b0;
    total_cnt++;
    if (bad_res !== 0) $display("FAIL b2b_results: %0d wrong sums, required 0", bad_res);
    else pass_cnt++;
    total_cnt++;
    if (bad_tim !== 0) $display("FAIL b2b_timing: %0d done/stability errors, required 0", bad_tim);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_stop: busy=%b done=%b, required 0 0", busy, done);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_bit_serial_adder4
